// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state encodings and sizing helpers
// used by the digit-serial adder and its ripple slice.
package arith_pkg;

    // Serial adder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..steps-1.
    // Never narrower than one bit, so STEPS=1 still gets a real register.
    function automatic int cnt_width(input int steps);
        int w;
        w = $clog2(steps);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    // Sum and majority carry.
    always_comb begin
        s_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/rca_digit.sv
// DIGIT-bit combinational ripple-carry slice built from fa cells.
// Also exposes the carry into the slice MSB so the caller can form the
// signed-overflow flag on the final digit.
module rca_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             carry_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             carry_out_o,
    output logic             msb_carry_in_o
);

    // c[i] is the carry into bit i; c[DIGIT] leaves the slice.
    logic [DIGIT:0] c;

    assign c[0] = carry_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        fa u_fa (
            .a_i   (a_i[i]),
            .b_i   (b_i[i]),
            .cin_i (c[i]),
            .s_o   (sum_o[i]),
            .cout_o(c[i+1])
        );
    end

    assign carry_out_o    = c[DIGIT];
    assign msb_carry_in_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. Operands are accepted on a valid/ready
// handshake, summed DIGIT bits per cycle LSB first through one ripple
// slice, and the result is returned on a second valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is combinational from state and out_ready so a
// result can be retired and new operands accepted on the same edge.
// out_valid, once high, only drops after an out_ready transfer or reset,
// and sum/carry_out/overflow stay stable while it is high.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [1:0]       dbg_state_o
);

    // Elaboration-time parameter legality.
    if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "serial_adder: WIDTH must be >=1 and a multiple of DIGIT>=1");
    end

    localparam int STEPS = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_msb_cin;
    logic              accept;

    // One ripple slice shared across all steps.
    rca_digit #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a_i           (a_q[DIGIT-1:0]),
        .b_i           (b_q[DIGIT-1:0]),
        .carry_i       (carry_q),
        .sum_o         (slice_sum),
        .carry_out_o   (slice_cout),
        .msb_carry_in_o(slice_msb_cin)
    );

    // Ready whenever idle, or when the pending result is being taken now.
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Next-state logic; operand load on acceptance overrides the per-state update.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                // Slice result enters at the top; after STEPS shifts the
                // first digit has reached bit 0.
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_msb_cin ^ slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Subtraction is A + ~B + 1: invert B and force the initial carry.
        if (accept) begin
            a_d     = src1;
            b_d     = sub ? ~src2 : src2;
            carry_d = sub ? 1'b1 : carry_in;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output drive.
    always_comb begin
        out_valid   = (state_q == DONE);
        sum         = sum_q;
        carry_out   = cout_q;
        overflow    = ovf_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: one instance with DIGIT=1 and one with
// DIGIT=4, both WIDTH=8, sharing clock and reset.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DIGIT=1 instance signals
    logic       d1_in_valid, d1_in_ready, d1_carry_in, d1_sub;
    logic       d1_out_valid, d1_out_ready, d1_carry_out, d1_overflow;
    logic [7:0] d1_src1, d1_src2, d1_sum;
    logic [1:0] d1_state;

    // DIGIT=4 instance signals
    logic       d4_in_valid, d4_in_ready, d4_carry_in, d4_sub;
    logic       d4_out_valid, d4_out_ready, d4_carry_out, d4_overflow;
    logic [7:0] d4_src1, d4_src2, d4_sum;
    logic [1:0] d4_state;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d1_in_valid),
        .in_ready   (d1_in_ready),
        .src1       (d1_src1),
        .src2       (d1_src2),
        .carry_in   (d1_carry_in),
        .sub        (d1_sub),
        .out_valid  (d1_out_valid),
        .out_ready  (d1_out_ready),
        .sum        (d1_sum),
        .carry_out  (d1_carry_out),
        .overflow   (d1_overflow),
        .dbg_state_o(d1_state)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d4_in_valid),
        .in_ready   (d4_in_ready),
        .src1       (d4_src1),
        .src2       (d4_src2),
        .carry_in   (d4_carry_in),
        .sub        (d4_sub),
        .out_valid  (d4_out_valid),
        .out_ready  (d4_out_ready),
        .sum        (d4_sum),
        .carry_out  (d4_carry_out),
        .overflow   (d4_overflow),
        .dbg_state_o(d4_state)
    );

    // Present operands to dut1, wait for acceptance, scramble the operand
    // inputs, then count cycles until out_valid (bounded).
    task automatic run_op1(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sb, output int lat);
        int w;
        d1_src1 = a; d1_src2 = b; d1_carry_in = cin; d1_sub = sb;
        d1_in_valid = 1'b1;
        w = 0;
        while (!d1_in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        d1_in_valid = 1'b0;
        d1_src1 = 8'($urandom_range(0, 255));
        d1_src2 = 8'($urandom_range(0, 255));
        d1_carry_in = 1'($urandom_range(0, 1));
        d1_sub = 1'($urandom_range(0, 1));
        lat = 0;
        while (!d1_out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_op4(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sb, output int lat);
        int w;
        d4_src1 = a; d4_src2 = b; d4_carry_in = cin; d4_sub = sb;
        d4_in_valid = 1'b1;
        w = 0;
        while (!d4_in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        d4_in_valid = 1'b0;
        d4_src1 = 8'($urandom_range(0, 255));
        d4_src2 = 8'($urandom_range(0, 255));
        lat = 0;
        while (!d4_out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d1_in_valid = 1'b1; d1_src1 = 8'h12; d1_src2 = 8'h34;
        d1_carry_in = 1'b0; d1_sub = 1'b0; d1_out_ready = 1'b1;
        d4_in_valid = 1'b0; d4_src1 = 8'h00; d4_src2 = 8'h00;
        d4_carry_in = 1'b0; d4_sub = 1'b0; d4_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (d1_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_no_accept: state=%0d expected=0", d1_state);
        end
        d1_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs_d1: out_valid=%b in_ready=%b expected 0/1", d1_out_valid, d1_in_ready);
        end
        checks++;
        if (d1_sum !== 8'h00 || d1_carry_out !== 1'b0 || d1_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_d1: sum=%h co=%b ov=%b expected 00/0/0", d1_sum, d1_carry_out, d1_overflow);
        end
        checks++;
        if (d4_out_valid !== 1'b0 || d4_in_ready !== 1'b1 || d4_sum !== 8'h00) begin
            errors++;
            $display("FAIL reset_d4: out_valid=%b in_ready=%b sum=%h expected 0/1/00", d4_out_valid, d4_in_ready, d4_sum);
        end
    endtask

    task automatic test_add();
        int lat;
        run_op1(8'h35, 8'h4A, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL add_latency: got=%0d expected=8", lat);
        end
        checks++;
        if (d1_sum !== 8'h7F || d1_carry_out !== 1'b0 || d1_overflow !== 1'b0) begin
            errors++;
            $display("FAIL add_35_4a: sum=%h co=%b ov=%b expected 7f/0/0", d1_sum, d1_carry_out, d1_overflow);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_op1(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 8 || d1_sum !== 8'h80 || d1_carry_out !== 1'b0 || d1_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_7f_01: lat=%0d sum=%h co=%b ov=%b expected 8/80/0/1", lat, d1_sum, d1_carry_out, d1_overflow);
        end
        run_op1(8'hFF, 8'h00, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 8 || d1_sum !== 8'h00 || d1_carry_out !== 1'b1 || d1_overflow !== 1'b0) begin
            errors++;
            $display("FAIL carry_ff_00_c1: lat=%0d sum=%h co=%b ov=%b expected 8/00/1/0", lat, d1_sum, d1_carry_out, d1_overflow);
        end
        // 0x10 - 0x20 on the bit-serial instance as well
        run_op1(8'h10, 8'h20, 1'b0, 1'b1, lat);
        checks++;
        if (d1_sum !== 8'hF0 || d1_carry_out !== 1'b0 || d1_overflow !== 1'b0) begin
            errors++;
            $display("FAIL sub_d1: sum=%h co=%b ov=%b expected f0/0/0", d1_sum, d1_carry_out, d1_overflow);
        end
    endtask

    task automatic test_digit4();
        int lat;
        run_op4(8'h10, 8'h20, 1'b1, 1'b1, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL d4_latency: got=%0d expected=2", lat);
        end
        checks++;
        if (d4_sum !== 8'hF0 || d4_carry_out !== 1'b0 || d4_overflow !== 1'b0) begin
            errors++;
            $display("FAIL d4_sub_10_20: sum=%h co=%b ov=%b expected f0/0/0", d4_sum, d4_carry_out, d4_overflow);
        end
        run_op4(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 2 || d4_sum !== 8'h80 || d4_carry_out !== 1'b0 || d4_overflow !== 1'b1) begin
            errors++;
            $display("FAIL d4_ovf_7f_01: lat=%0d sum=%h co=%b ov=%b expected 2/80/0/1", lat, d4_sum, d4_carry_out, d4_overflow);
        end
        // 0x20 - 0x10: no borrow, so carry_out=1
        run_op4(8'h20, 8'h10, 1'b0, 1'b1, lat);
        checks++;
        if (d4_sum !== 8'h10 || d4_carry_out !== 1'b1 || d4_overflow !== 1'b0) begin
            errors++;
            $display("FAIL d4_sub_20_10: sum=%h co=%b ov=%b expected 10/1/0", d4_sum, d4_carry_out, d4_overflow);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        d1_out_ready = 1'b0;
        run_op1(8'h35, 8'h4A, 1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (d1_out_valid !== 1'b1 || d1_in_ready !== 1'b0 || d1_sum !== 8'h7F ||
                d1_carry_out !== 1'b0 || d1_overflow !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b sum=%h co=%b ovf=%b expected 1/0/7f/0/0",
                         i, d1_out_valid, d1_in_ready, d1_sum, d1_carry_out, d1_overflow);
            end
        end
        d1_out_ready = 1'b1;
        d1_in_valid = 1'b1;
        d1_src1 = 8'hFF; d1_src2 = 8'hFF; d1_carry_in = 1'b1; d1_sub = 1'b0;
        #1;
        checks++;
        if (d1_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: in_ready=%b expected=1", d1_in_ready);
        end
        @(posedge clk); #1;
        d1_in_valid = 1'b0;
        checks++;
        if (d1_out_valid !== 1'b0 || d1_state !== 2'd1) begin
            errors++;
            $display("FAIL bp_same_edge: out_valid=%b state=%0d expected 0/1", d1_out_valid, d1_state);
        end
        lat = 0;
        while (!d1_out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 8 || d1_sum !== 8'hFF || d1_carry_out !== 1'b1 || d1_overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_ff_ff_c1: lat=%0d sum=%h co=%b ov=%b expected 8/ff/1/0", lat, d1_sum, d1_carry_out, d1_overflow);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int stale;
        d1_src1 = 8'hAA; d1_src2 = 8'h55; d1_carry_in = 1'b0; d1_sub = 1'b0;
        d1_in_valid = 1'b1;
        @(posedge clk); #1;
        d1_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1 || d1_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_async: out_valid=%b in_ready=%b state=%0d expected 0/1/0", d1_out_valid, d1_in_ready, d1_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL rst_no_stale: bad_cycles=%0d expected=0", stale);
        end
        run_op1(8'h01, 8'h01, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 8 || d1_sum !== 8'h02 || d1_carry_out !== 1'b0 || d1_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_then_add: lat=%0d sum=%h co=%b ov=%b expected 8/02/0/0", lat, d1_sum, d1_carry_out, d1_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_digit4();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised digit-serial adder/subtractor. It accepts two WIDTH-bit operands through a valid/ready handshake and adds them DIGIT bits per cycle, LSB first, using a single DIGIT-bit ripple slice built from the `fa` full-adder cell. It returns sum, carry-out and signed overflow through a second valid/ready handshake. It is the area-lean successor to the combinational `fa`/ripple adders in the arithmetic library, for datapaths that can trade latency for area.

## Interface
- WIDTH, 8: operand and sum width; must be ≥1.
- DIGIT, 1: bits processed per cycle; must be ≥1 and divide WIDTH exactly. STEPS = WIDTH/DIGIT.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; combinational from state and out_ready.
- src1  input  WIDTH  operand A; sampled only on acceptance.
- src2  input  WIDTH  operand B; sampled only on acceptance.
- carry_in  input  1  carry into bit 0 for add; ignored when sub=1.
- sub  input  1  0 = src1+src2+carry_in; 1 = src1+~src2+1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0 and out_valid=0.
  - DONE: out_valid=1.
- Acceptance is in_valid && in_ready at a rising edge. On acceptance:
  - capture src1 into the A shift register.
  - capture src2 (inverted if sub) into the B shift register.
  - load the carry register with carry_in, or with 1 if sub.
  - clear the step counter and enter RUN.
- Each RUN cycle:
  - the slice adds A[DIGIT-1:0] + B[DIGIT-1:0] + carry.
  - A and B shift right by DIGIT.
  - the slice sum shifts into the top DIGIT bits of the sum register.
  - the carry register takes the slice carry-out.
  - the counter increments.
- On the step where counter = STEPS-1:
  - carry_out is loaded with the slice carry-out.
  - overflow is loaded with the slice MSB carry-in XOR the slice carry-out.
  - the state moves to DONE.
- DONE:
  - if out_ready=0, hold the state; sum, carry_out and overflow stay stable.
  - if out_ready=1 and in_valid=0, go to IDLE.
  - if out_ready=1 and in_valid=1, retire the result and accept new operands on the same edge, then go to RUN.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- sum, carry_out and overflow are meaningful only while out_valid=1.
  - They hold their last value through IDLE.
  - They are undefined during RUN.
- All arithmetic is modulo 2^WIDTH. There is no sign extension.

## Timing
- Reset values:
  - state IDLE.
  - out_valid=0, sum=0, carry_out=0, overflow=0.
  - counter=0, carry register=0.
  - in_ready=1 once rst deasserts.
  - No acceptance occurs while rst=1.
- Latency: out_valid rises STEPS cycles after the acceptance edge.
- Throughput: one result per STEPS+1 cycles with out_ready held high.
- STEPS=1: a single RUN cycle, then DONE.
- Operand inputs may change freely after the acceptance edge.
- Reset asserted mid-RUN or mid-DONE:
  - state goes to IDLE and out_valid goes to 0 immediately (asynchronously).
  - the operation in flight is discarded and no result is produced.
- out_valid is never deasserted without an out_ready handshake, except by reset.

## Structure
- Shared arithmetic package/header (arith_pkg) holds:
  - the state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - a clog2-based helper for the counter width, with a minimum of 1.
- One sub-module: `rca_digit` #(DIGIT).
  - A DIGIT-bit combinational ripple of `fa` instances.
  - Outputs sum, carry_out and msb_carry_in.
- Parameter legality (WIDTH % DIGIT == 0, DIGIT ≥ 1) is checked at elaboration with a fatal error.

## Test plan
- WIDTH=8, DIGIT=1: add 8'h35+8'h4A, carry_in=0.
  - sum=8'h7F, carry_out=0, overflow=0.
  - out_valid rises exactly 8 cycles after acceptance.
- WIDTH=8, DIGIT=1:
  - 8'h7F+8'h01 → sum=8'h80, overflow=1, carry_out=0.
  - 8'hFF+8'h00 with carry_in=1 → sum=8'h00, carry_out=1, overflow=0.
- WIDTH=8, DIGIT=4, sub=1: 8'h10−8'h20, carry_in=1 (ignored).
  - sum=8'hF0, carry_out=0, overflow=0.
  - Latency 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - sum, carry_out and overflow stay stable.
  - in_ready=0.
  - Then raise out_ready together with in_valid and new operands (8'hFF+8'hFF, carry_in=1): new acceptance on the same edge, with result sum=8'hFF, carry_out=1.
- Reset mid-operation: assert rst at RUN step 3 of 8.
  - out_valid=0 and in_ready=1 after release.
  - No stale result appears.
  - A following 8'h01+8'h01 gives sum=8'h02.
